// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU result channel and a FIFO-buffered memory result channel
// into one registered register-file write port. Define WB_ROUND_ROBIN_EN for round-robin arbitration.
module wb_arbiter #(
    parameter int DATA_W   = 19,
    parameter int ADDR_W   = 4,
    parameter int MQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      alu_valid,
    input  logic [ADDR_W-1:0]         alu_rd,
    input  logic [DATA_W-1:0]         alu_data,
    output logic                      alu_ready,
    input  logic                      mem_valid,
    input  logic [ADDR_W-1:0]         mem_rd,
    input  logic [DATA_W-1:0]         mem_data,
    output logic                      mem_ready,
    output logic [ADDR_W-1:0]         wb_rd,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      wb_regwrite,
    output logic [$clog2(MQ_DEPTH):0] mq_count,
    output logic                      busy
);

    localparam int PW = $clog2(MQ_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] mq_rd_q   [MQ_DEPTH];
    logic [ADDR_W-1:0] mq_rd_d   [MQ_DEPTH];
    logic [DATA_W-1:0] mq_data_q [MQ_DEPTH];
    logic [DATA_W-1:0] mq_data_d [MQ_DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_regwrite_q, wb_regwrite_d;

    logic fifo_req;
    logic grant_alu;
    logic pop;
    logic push;

    assign fifo_req  = (count_q != '0);
    assign mem_ready = (count_q < CW'(MQ_DEPTH));

`ifdef WB_ROUND_ROBIN_EN
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e last_grant_q, last_grant_d;

    // FIFO head gets its turn only right after an ALU grant; resetting to GRANT_MEM puts the ALU first.
    assign alu_ready = !(last_grant_q == GRANT_ALU && fifo_req);

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_alu) begin
            last_grant_d = GRANT_ALU;
        end else if (pop) begin
            last_grant_d = GRANT_MEM;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= GRANT_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign alu_ready = 1'b1;
`endif

    assign grant_alu = alu_valid & alu_ready;
    assign pop       = !grant_alu & fifo_req;
    assign push      = mem_valid & mem_ready;

    always_comb begin
        mq_rd_d   = mq_rd_q;
        mq_data_d = mq_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (push) begin
            mq_rd_d[wr_ptr_q]   = mem_rd;
            mq_data_d[wr_ptr_q] = mem_data;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Writes to register 0 are consumed like any other grant but never raise regwrite.
    always_comb begin
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        wb_regwrite_d = 1'b0;
        if (grant_alu) begin
            wb_rd_d       = alu_rd;
            wb_data_d     = alu_data;
            wb_regwrite_d = (alu_rd != '0);
        end else if (pop) begin
            wb_rd_d       = mq_rd_q[rd_ptr_q];
            wb_data_d     = mq_data_q[rd_ptr_q];
            wb_regwrite_d = (mq_rd_q[rd_ptr_q] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MQ_DEPTH; i++) begin
                mq_rd_q[i]   <= '0;
                mq_data_q[i] <= '0;
            end
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            wb_regwrite_q <= 1'b0;
        end else begin
            mq_rd_q       <= mq_rd_d;
            mq_data_q     <= mq_data_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            wb_regwrite_q <= wb_regwrite_d;
        end
    end

    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign wb_regwrite = wb_regwrite_q;
    assign mq_count    = count_q;
    assign busy        = fifo_req | wb_regwrite_q;

endmodule
